// File: rtl/color_frame_classifier.sv
// color_frame_classifier
// Counts red-class and blue-class RGB332 samples per camera frame and, one
// cycle after each VSYNC rising edge, issues a registered dominant-colour
// decision (00 none, 01 red, 10 blue) with a one-cycle valid pulse.
// The first partial frame after reset is always discarded.
// Optional build macro CLASSIFIER_ROI_EN: when defined, only samples inside
// the rectangle X_LO<=X_IN<X_HI, Y_LO<=Y_IN<Y_HI are counted; otherwise the
// coordinates are ignored.
module color_frame_classifier #(
  parameter int unsigned CNT_W   = 15,
  parameter int unsigned R_MIN   = 5,
  parameter int unsigned B_MIN   = 2,
  parameter int unsigned MIN_CNT = 400,
  parameter int unsigned X_LO    = 44,
  parameter int unsigned X_HI    = 132,
  parameter int unsigned Y_LO    = 36,
  parameter int unsigned Y_HI    = 108
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [7:0]       PIXEL,
  input  logic             SAMP_RDY,
  input  logic [14:0]      X_IN,
  input  logic [14:0]      Y_IN,
  input  logic             VSYNC,
  output logic [1:0]       RESULT,
  output logic             RESULT_VLD,
  output logic [CNT_W-1:0] RED_CNT,
  output logic [CNT_W-1:0] BLUE_CNT
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2
  } state_e;

  localparam logic [1:0]       RES_NONE = 2'b00;
  localparam logic [1:0]       RES_RED  = 2'b01;
  localparam logic [1:0]       RES_BLUE = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q;
  logic             vsync_q;
  logic [CNT_W-1:0] red_acc_q, blue_acc_q;
  logic [CNT_W-1:0] red_cnt_q, blue_cnt_q;
  logic [1:0]       result_q;
  logic             result_vld_q;

  logic [2:0]       r_f, g_f;
  logic [1:0]       b_f;
  logic             is_red, is_blue, in_roi, vrise;
  logic             count_red, count_blue;
  logic [CNT_W-1:0] red_acc_d, blue_acc_d;
  logic [1:0]       result_d;

  // Colour classes: red and blue are disjoint (red needs R>=5, blue R<=2).
  assign {r_f, g_f, b_f} = PIXEL;
  assign is_red  = (r_f >= 3'(R_MIN)) && (g_f <= 3'd2) && (b_f <= 2'd1);
  assign is_blue = (b_f >= 2'(B_MIN)) && (r_f <= 3'd2) && (g_f <= 3'd3);

`ifdef CLASSIFIER_ROI_EN
  assign in_roi = (X_IN >= 15'(X_LO)) && (X_IN < 15'(X_HI)) &&
                  (Y_IN >= 15'(Y_LO)) && (Y_IN < 15'(Y_HI));
`else
  // Coordinates and ROI bounds are deliberately unused in this build.
  logic unused_roi;
  assign unused_roi = ^{X_IN, Y_IN, 15'(X_LO), 15'(X_HI), 15'(Y_LO), 15'(Y_HI)};
  assign in_roi     = 1'b1;
`endif

  assign vrise      = VSYNC && !vsync_q;
  assign count_red  = SAMP_RDY && in_roi && is_red;
  assign count_blue = SAMP_RDY && in_roi && is_blue;

  // Saturating increments: a full counter stays at all-ones.
  assign red_acc_d  = (red_acc_q  == CNT_MAX) ? red_acc_q  : red_acc_q  + CNT_W'(1);
  assign blue_acc_d = (blue_acc_q == CNT_MAX) ? blue_acc_q : blue_acc_q + CNT_W'(1);

  // Dominant-colour decision from the last completed frame's counts; ties report none.
  always_comb begin
    // NOTE: default assigned first so every path drives result_d and no latch is inferred.
    result_d = RES_NONE;
    if ((red_cnt_q > blue_cnt_q) && (red_cnt_q >= CNT_W'(MIN_CNT))) begin
      result_d = RES_RED;
    end else if ((blue_cnt_q > red_cnt_q) && (blue_cnt_q >= CNT_W'(MIN_CNT))) begin
      result_d = RES_BLUE;
    end
  end

  // Frame FSM: accumulate, latch counts on VSYNC rise, decide on the following cycle.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q      <= ST_SYNC;
      vsync_q      <= 1'b0;
      red_acc_q    <= '0;
      blue_acc_q   <= '0;
      red_cnt_q    <= '0;
      blue_cnt_q   <= '0;
      result_q     <= RES_NONE;
      result_vld_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      vsync_q      <= VSYNC;
      result_vld_q <= 1'b0;
      unique case (state_q)
        ST_SYNC: begin
          // Partial frame after reset: samples are discarded until the first edge.
          if (vrise) begin
            state_q    <= ST_ACCUM;
            red_acc_q  <= '0;
            blue_acc_q <= '0;
          end
        end
        ST_ACCUM: begin
          if (vrise) begin
            // A sample coincident with the edge belongs to neither frame.
            state_q    <= ST_DECIDE;
            red_cnt_q  <= red_acc_q;
            blue_cnt_q <= blue_acc_q;
            red_acc_q  <= '0;
            blue_acc_q <= '0;
          end else begin
            if (count_red)  red_acc_q  <= red_acc_d;
            if (count_blue) blue_acc_q <= blue_acc_d;
          end
        end
        ST_DECIDE: begin
          // vsync_q is high here, so no edge can occur; samples go to the new frame.
          state_q      <= ST_ACCUM;
          result_q     <= result_d;
          result_vld_q <= 1'b1;
          if (count_red)  red_acc_q  <= red_acc_d;
          if (count_blue) blue_acc_q <= blue_acc_d;
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign RESULT     = result_q;
  assign RESULT_VLD = result_vld_q;
  assign RED_CNT    = red_cnt_q;
  assign BLUE_CNT   = blue_cnt_q;

endmodule

// File: tb/tb_color_frame_classifier.sv
// Testbench for color_frame_classifier: table-driven frames with hand-computed
// expectations, hand-written reset/edge sequences, and randomized frames
// checked against a sample-level reference model of the classification rules.
module tb_color_frame_classifier;

  localparam int CNT_W   = 15;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MIN_CNT = 400;
`ifdef CLASSIFIER_ROI_EN
  localparam int EXP_ROI = 410;
`else
  localparam int EXP_ROI = 1010;
`endif

  logic             CLK = 1'b0;
  logic             RES = 1'b1;
  logic [7:0]       PIXEL = 8'h00;
  logic             SAMP_RDY = 1'b0;
  logic [14:0]      X_IN = 15'd80;
  logic [14:0]      Y_IN = 15'd60;
  logic             VSYNC = 1'b0;
  logic [1:0]       RESULT;
  logic             RESULT_VLD;
  logic [CNT_W-1:0] RED_CNT;
  logic [CNT_W-1:0] BLUE_CNT;

  color_frame_classifier #(.CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RES        (RES),
    .PIXEL      (PIXEL),
    .SAMP_RDY   (SAMP_RDY),
    .X_IN       (X_IN),
    .Y_IN       (Y_IN),
    .VSYNC      (VSYNC),
    .RESULT     (RESULT),
    .RESULT_VLD (RESULT_VLD),
    .RED_CNT    (RED_CNT),
    .BLUE_CNT   (BLUE_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err = 0;
  int vld_pulses = 0;
  int exp_pulses = 0;
  int bad_code = 0;
  int m_red = 0;
  int m_blue = 0;
  logic [1:0] last_res = 2'b00;

  typedef struct {
    string      name;
    logic [7:0] red_px;
    int         n_red;
    logic [7:0] blue_px;
    int         n_blue;
    logic [7:0] other_px;
    int         n_other;
    int         exp_red;
    int         exp_blue;
    logic [1:0] exp_res;
  } frame_vec_t;

  frame_vec_t vecs[8];

  // Observe the result pins away from the active edge.
  always @(negedge CLK) begin
    if (RESULT_VLD === 1'b1) vld_pulses++;
    if (RESULT === 2'b11) bad_code++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: classification straight from the RGB332 field rules.
  function automatic bit ref_red(input int p);
    int r = p / 32;
    int g = (p / 4) % 8;
    int b = p % 4;
    return (r >= 5) && (g <= 2) && (b <= 1);
  endfunction

  function automatic bit ref_blue(input int p);
    int r = p / 32;
    int g = (p / 4) % 8;
    int b = p % 4;
    return (b >= 2) && (r <= 2) && (g <= 3);
  endfunction

  function automatic bit ref_roi(input int x, input int y);
`ifdef CLASSIFIER_ROI_EN
    return (x >= 44) && (x < 132) && (y >= 36) && (y < 108);
`else
    return (x >= 0) || (y >= 0);
`endif
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic logic [1:0] ref_decide(input int r, input int b);
    if (r > b && r >= MIN_CNT) return 2'b01;
    if (b > r && b >= MIN_CNT) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] rand_px(input int wr, input int wb);
    int s = int'($urandom_range(0, 99));
    if (s < wr)
      return {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 1))};
    if (s < wr + wb)
      return {3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 2'($urandom_range(2, 3))};
    return 8'($urandom);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One cycle of stimulus; the model only tallies samples that reach the counters.
  task automatic apply(input bit rdy, input logic [7:0] px, input int x, input int y);
    SAMP_RDY = rdy;
    PIXEL    = px;
    X_IN     = 15'(x);
    Y_IN     = 15'(y);
    tick();
    SAMP_RDY = 1'b0;
    if (rdy && ref_roi(x, y)) begin
      if (ref_red(int'(px)))  m_red++;
      if (ref_blue(int'(px))) m_blue++;
    end
  endtask

  task automatic burst(input logic [7:0] px, input int n, input int x, input int y);
    for (int i = 0; i < n; i++) apply(1'b1, px, x, y);
  endtask

  // Raise VSYNC and check the count/decision timeline around the edge.
  task automatic end_frame(input string nm, input int exp_r, input int exp_b,
                           input logic [1:0] exp_res, input bit decide,
                           input bit edge_rdy, input bit busy);
    VSYNC    = 1'b1;
    SAMP_RDY = edge_rdy;
    PIXEL    = 8'hE0;
    X_IN     = 15'd80;
    Y_IN     = 15'd60;
    tick();
    SAMP_RDY = 1'b0;
    check({nm, ".red_cnt"}, RED_CNT, exp_r);
    check({nm, ".blue_cnt"}, BLUE_CNT, exp_b);
    check({nm, ".vld_edge"}, RESULT_VLD, 0);
    m_red  = 0;
    m_blue = 0;
    apply(busy, rand_px(30, 30), 80, 60);
    if (decide) begin
      check({nm, ".vld_pulse"}, RESULT_VLD, 1);
      check({nm, ".result"}, RESULT, exp_res);
      last_res = exp_res;
      exp_pulses++;
    end else begin
      check({nm, ".no_vld"}, RESULT_VLD, 0);
      check({nm, ".result_hold"}, RESULT, last_res);
    end
    apply(busy, rand_px(30, 30), 80, 60);
    check({nm, ".vld_end"}, RESULT_VLD, 0);
    check({nm, ".result_kept"}, RESULT, last_res);
    for (int i = 0; i < 3; i++) apply(busy, rand_px(30, 30), 80, 60);
    check({nm, ".vld_vsync_held"}, RESULT_VLD, 0);
    VSYNC = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{"red500",    8'hE0, 500, 8'h03,   0, 8'hFF,  0, 500,   0, 2'b01};
    vecs[1] = '{"mix",       8'hE0, 200, 8'h03, 300, 8'hFF,  0, 200, 300, 2'b00};
    vecs[2] = '{"blue600",   8'hE0,   0, 8'h03, 600, 8'hFF,  0,   0, 600, 2'b10};
    vecs[3] = '{"tie450",    8'hE0, 450, 8'h03, 450, 8'hFF,  0, 450, 450, 2'b00};
    vecs[4] = '{"below_min", 8'hA9, 399, 8'h4E,   0, 8'h80, 50, 399,   0, 2'b00};
    vecs[5] = '{"at_min",    8'hA9, 400, 8'h4E, 399, 8'hAD, 30, 400, 399, 2'b01};
    vecs[6] = '{"blue_edge", 8'hE0, 100, 8'h4E, 401, 8'h01, 40, 100, 401, 2'b10};
    vecs[7] = '{"empty",     8'hE0,   0, 8'h03,   0, 8'hFF,  0,   0,   0, 2'b00};

    // Reset state.
    RES = 1'b1;
    repeat (2) tick();
    check("reset.result", RESULT, 0);
    check("reset.vld", RESULT_VLD, 0);
    check("reset.red_cnt", RED_CNT, 0);
    check("reset.blue_cnt", BLUE_CNT, 0);
    RES = 1'b0;
    tick();

    // Samples before the first edge are discarded and no decision is issued.
    burst(8'hE0, 1000, 80, 60);
    end_frame("presync", 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Table-driven frames with hand-computed results.
    for (int i = 0; i < 8; i++) begin
      burst(vecs[i].red_px, vecs[i].n_red, 80, 60);
      burst(vecs[i].blue_px, vecs[i].n_blue, 80, 60);
      burst(vecs[i].other_px, vecs[i].n_other, 80, 60);
      end_frame(vecs[i].name, vecs[i].exp_red, vecs[i].exp_blue, vecs[i].exp_res,
                1'b1, 1'b0, 1'b0);
    end

    // A red sample coincident with the edge is dropped.
    burst(8'hE0, 410, 80, 60);
    end_frame("coincident", 410, 0, 2'b01, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-frame clears outputs before any clock edge.
    burst(8'hE0, 100, 80, 60);
    #2;
    RES = 1'b1;
    #1;
    check("midreset.result", RESULT, 0);
    check("midreset.vld", RESULT_VLD, 0);
    check("midreset.red_cnt", RED_CNT, 0);
    check("midreset.blue_cnt", BLUE_CNT, 0);
    last_res = 2'b00;
    tick();
    RES = 1'b0;
    tick();
    burst(8'hE0, 500, 80, 60);
    end_frame("post_reset", 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    burst(8'hE0, 450, 80, 60);
    end_frame("after_reset", 450, 0, 2'b01, 1'b1, 1'b0, 1'b0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 6; f++) begin
      int wr = int'($urandom_range(0, 60));
      int wb = int'($urandom_range(0, 100 - wr));
      int n  = int'($urandom_range(300, 1200));
      for (int i = 0; i < n; i++) begin
        apply($urandom_range(0, 3) != 0, rand_px(wr, wb),
              int'($urandom_range(0, 175)), int'($urandom_range(0, 143)));
      end
      end_frame($sformatf("rand%0d", f), sat(m_red), sat(m_blue),
                ref_decide(sat(m_red), sat(m_blue)), 1'b1,
                1'($urandom_range(0, 1)), 1'b1);
    end
    end_frame("flush", sat(m_red), sat(m_blue), ref_decide(sat(m_red), sat(m_blue)),
              1'b1, 1'b0, 1'b0);

    // ROI: samples outside the window count only when the window is disabled.
    burst(8'hE0, 600, 10, 10);
    burst(8'hE0, 410, 80, 60);
    end_frame("roi", EXP_ROI, 0, 2'b01, 1'b1, 1'b0, 1'b0);

    // Saturation: counter sticks at all-ones.
    burst(8'hE0, CNT_MAX + 33, 80, 60);
    end_frame("saturate", CNT_MAX, 0, 2'b01, 1'b1, 1'b0, 1'b0);

    check("total_vld_pulses", vld_pulses, exp_pulses);
    check("result_code_11_seen", bad_code, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/color_frame_classifier.md
Name: color_frame_classifier

Overview:
- Sits directly downstream of the camera downsampler.
- Consumes its RGB332 pixel stream (PIXEL, SAMP_RDY, x/y coordinates) plus raw VSYNC.
- Counts red-class and blue-class pixels per frame and, at each frame boundary, issues a registered dominant-colour decision for the Arduino-facing result pins.

Parameters:
- CNT_W, 15: width of per-frame pixel counters; counters saturate at 2^CNT_W-1.
- R_MIN, 5: minimum 3-bit R field for a red-class pixel.
- B_MIN, 2: minimum 2-bit B field for a blue-class pixel.
- MIN_CNT, 400: minimum winning count required to report a colour.
- X_LO, 44: ROI left bound, inclusive (ROI build only).
- X_HI, 132: ROI right bound, exclusive.
- Y_LO, 36: ROI top bound, inclusive.
- Y_HI, 108: ROI bottom bound, exclusive.

Ports:
- CLK, input, 1: pixel clock, same domain as downsampler.
- RES, input, 1: reset, asynchronous, active-high.
- PIXEL, input, 8: RGB332 sample, {R[7:5],G[4:2],B[1:0]}.
- SAMP_RDY, input, 1: PIXEL/X_IN/Y_IN valid this cycle.
- X_IN, input, 15: column of current sample.
- Y_IN, input, 15: row of current sample.
- VSYNC, input, 1: camera VSYNC; rising edge ends a frame.
- RESULT, output, 2: 00 none, 01 red, 10 blue; 11 never driven.
- RESULT_VLD, output, 1: one-cycle pulse when RESULT updates.
- RED_CNT, output, CNT_W: red count of last completed frame.
- BLUE_CNT, output, CNT_W: blue count of last completed frame.

Behaviour:
- Reset (async assert, sync release):
  - FSM=SYNC, counters=0, RESULT=00, RESULT_VLD=0, RED_CNT=0, BLUE_CNT=0, vsync_q=0.
- Classification (combinational on PIXEL):
  - red = R>=R_MIN && G<=2 && B<=1.
  - blue = B>=B_MIN && R<=2 && G<=3.
  - The two classes are mutually exclusive by construction; neither class = ignored.
- Edge detect: vrise = VSYNC && !vsync_q; vsync_q registered every cycle.
- FSM states SYNC, ACCUM, DECIDE:
  - SYNC: discard all samples (partial first frame after reset). On vrise go ACCUM, clear counters, no decision issued.
  - ACCUM: on SAMP_RDY with red (blue), increment red_acc (blue_acc), saturating. On vrise go DECIDE; in that same edge copy red_acc/blue_acc into RED_CNT/BLUE_CNT and clear the accumulators.
  - DECIDE (exactly 1 cycle): compute RESULT from RED_CNT/BLUE_CNT and go ACCUM.
    - 01 if RED_CNT>BLUE_CNT and RED_CNT>=MIN_CNT.
    - 10 if BLUE_CNT>RED_CNT and BLUE_CNT>=MIN_CNT.
    - 00 otherwise, including ties.
    - RESULT_VLD=1 for this edge's output only.
- Latency: vrise seen at edge k; RED_CNT/BLUE_CNT valid after k; RESULT and RESULT_VLD=1 after k+1; RESULT_VLD=0 after k+2. RESULT holds until the next decision.
- Simultaneous SAMP_RDY and vrise: that sample is dropped, not counted in either frame.
- Samples arriving while in DECIDE are counted into the new frame.
- VSYNC held high for many cycles: only one vrise and one decision. SAMP_RDY while VSYNC high is still counted (downsampler does not emit during VSYNC).
- Saturation: counter stays at all-ones; no wrap.
- RES mid-frame: everything returns to reset values; next frame is discarded (SYNC).

Optional Feature:
- Macro CLASSIFIER_ROI_EN.
- Defined: a sample is counted only if X_LO<=X_IN<X_HI and Y_LO<=Y_IN<Y_HI, compared unsigned at 15 bits.
- Undefined: X_IN/Y_IN are ignored and every valid sample is counted; X_*/Y_* parameters are unused.

Test Plan:
- Reset, then VSYNC rise, then 500 samples 8'hE0 (red), then VSYNC rise -> RED_CNT=500, BLUE_CNT=0; RESULT=01 with RESULT_VLD high exactly one cycle, one cycle after the edge.
- Frame of 300 blue (8'h03) + 200 red -> RED_CNT=200, BLUE_CNT=300, RESULT=00 (300<MIN_CNT); next frame 600 blue -> RESULT=10.
- Tie: 450 red + 450 blue -> RESULT=00, RESULT_VLD pulses.
- Samples before the first post-reset VSYNC rise (1000 red) -> no RESULT_VLD at that rise; RED_CNT=0 after it.
- SAMP_RDY red coincident with vrise, plus 410 red earlier -> RED_CNT=410; RES asserted mid-frame -> all outputs 0 immediately (async), first post-reset frame produces no decision.
- CLASSIFIER_ROI_EN defined: 600 red at (10,10) and 410 red at (80,60) -> RED_CNT=410, RESULT=01; undefined build: same stimulus -> RED_CNT=1010.
